// File: rtl/flags_ctrl.sv
// flags_ctrl
//   Owns the write port of the 3-bit condition-flags register {Z, V, N}.
//   It arbitrates flag updates from the ALU and the return-from-interrupt
//   path. It keeps a LIFO shadow stack of flags across nested interrupts.
//   It also evaluates branch conditions against the current flags.
//
// Ports
//   clk, rst_n   system clock; asynchronous active-low reset
//   alu_we       ALU requests a flag update this cycle
//   alu_flags    new flags {Z, V, N}
//   int_save     one-cycle pulse: interrupt accepted, push the current flags
//   rti          one-cycle pulse: return from interrupt, pop the flags
//   flags_q      current output of the flags register
//   cond         branch condition code
//   flags_en     write enable to the flags register
//   flags_d      write data to the flags register
//   busy         restore in progress; upstream must stall
//   take         branch condition true (combinational)
//   depth        number of occupied shadow-stack entries
//   ovf_err      sticky: push attempted while the stack was full
//   unf_err      sticky: pop attempted while the stack was empty
module flags_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_we,
    input  logic [2:0]                 alu_flags,
    input  logic                       int_save,
    input  logic                       rti,
    input  logic [2:0]                 flags_q,
    input  logic [2:0]                 cond,
    output logic                       flags_en,
    output logic [2:0]                 flags_d,
    output logic                       busy,
    output logic                       take,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        POP  = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [2:0]  stack [DEPTH];
    logic [2:0]  restore;

    logic        pop_start;
    logic        unf_req;
    logic        push_req;
    logic [2:0]  push_val;
    logic [AW:0] top;

    // A lone rti owns the cycle. It pops if the stack has data and flags
    // underflow if it does not. In both cases the ALU update is dropped.
    // rti together with int_save is a tail-chain and is a no-op for the stack.
    always_comb begin
        pop_start  = 1'b0;
        unf_req    = 1'b0;
        push_req   = 1'b0;
        push_val   = alu_we ? alu_flags : flags_q;
        top        = depth - (AW+1)'(1);
        state_next = state;
        flags_en   = 1'b0;
        flags_d    = flags_q;
        busy       = 1'b0;

        case (state)
            IDLE: begin
                if (rti && !int_save) begin
                    if (depth != '0) begin
                        pop_start  = 1'b1;
                        state_next = POP;
                    end else begin
                        unf_req = 1'b1;
                    end
                end else begin
                    push_req = int_save && !rti;
                    if (alu_we) begin
                        flags_en = 1'b1;
                        flags_d  = alu_flags;
                    end
                end
            end
            POP: begin
                busy       = 1'b1;
                flags_en   = 1'b1;
                flags_d    = restore;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Never write the flags register while reset is held.
        if (!rst_n) begin
            flags_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            depth   <= '0;
            restore <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (pop_start) begin
                restore <= stack[top[AW-1:0]];
                depth   <= top;
            end
            if (push_req) begin
                if (depth == FULL) begin
                    ovf_err <= 1'b1;
                end else begin
                    stack[depth[AW-1:0]] <= push_val;
                    depth                <= depth + (AW+1)'(1);
                end
            end
            if (unf_req) begin
                unf_err <= 1'b1;
            end
        end
    end

    // Branch condition evaluation; flags_q = {Z, V, N}.
    logic z, v, n, lt;
    always_comb begin
        z  = flags_q[2];
        v  = flags_q[1];
        n  = flags_q[0];
        lt = n ^ v;
        case (cond)
            3'b000:  take = 1'b1;
            3'b001:  take = z;
            3'b010:  take = !z;
            3'b011:  take = lt;
            3'b100:  take = !lt;
            3'b101:  take = !z && !lt;
            3'b110:  take = z || lt;
            default: take = v;
        endcase
    end

endmodule

// File: tb/tb_flags_ctrl.sv
// Testbench for flags_ctrl. It includes a behavioural model of the external
// flags register, fed from flags_en/flags_d. An override mux lets the
// condition sweep drive flags_q directly.
module tb_flags_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_we;
    logic [2:0] alu_flags;
    logic       int_save;
    logic       rti;
    logic [2:0] flags_q;
    logic [2:0] cond;
    logic       flags_en;
    logic [2:0] flags_d;
    logic       busy;
    logic       take;
    logic [2:0] depth;
    logic       ovf_err;
    logic       unf_err;

    logic [2:0] freg;
    logic       use_ext;
    logic [2:0] ext_flags;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        freg <= '0;
        else if (flags_en) freg <= flags_d;
    end

    assign flags_q = use_ext ? ext_flags : freg;

    flags_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_we    (alu_we),
        .alu_flags (alu_flags),
        .int_save  (int_save),
        .rti       (rti),
        .flags_q   (flags_q),
        .cond      (cond),
        .flags_en  (flags_en),
        .flags_d   (flags_d),
        .busy      (busy),
        .take      (take),
        .depth     (depth),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    typedef struct {
        logic [2:0] cond;
        logic [7:0] truth;   // bit f = expected take when flags_q == f
    } take_vec_t;

    typedef struct {
        logic       we;
        logic [2:0] alu;
        logic [2:0] cur;
        logic       exp_en;
        logic [2:0] exp_d;
    } wr_vec_t;

    take_vec_t take_tab [8];
    wr_vec_t   wr_tab   [5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        alu_we    = 1'b0;
        alu_flags = '0;
        int_save  = 1'b0;
        rti       = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    logic [2:0] vals [5];

    initial begin
        take_tab[0] = '{3'd0, 8'hFF};
        take_tab[1] = '{3'd1, 8'hF0};
        take_tab[2] = '{3'd2, 8'h0F};
        take_tab[3] = '{3'd3, 8'h66};
        take_tab[4] = '{3'd4, 8'h99};
        take_tab[5] = '{3'd5, 8'h09};
        take_tab[6] = '{3'd6, 8'hF6};
        take_tab[7] = '{3'd7, 8'hCC};

        wr_tab[0] = '{1'b0, 3'b111, 3'b010, 1'b0, 3'b010};
        wr_tab[1] = '{1'b1, 3'b111, 3'b010, 1'b1, 3'b111};
        wr_tab[2] = '{1'b1, 3'b000, 3'b101, 1'b1, 3'b000};
        wr_tab[3] = '{1'b0, 3'b001, 3'b110, 1'b0, 3'b110};
        wr_tab[4] = '{1'b1, 3'b011, 3'b011, 1'b1, 3'b011};

        vals[0] = 3'd1; vals[1] = 3'd2; vals[2] = 3'd3; vals[3] = 3'd4; vals[4] = 3'd5;

        use_ext   = 1'b0;
        ext_flags = '0;
        cond      = '0;
        clear_in();
        rst_n = 1'b0;
        #3;
        // ALU request held during reset must not write.
        alu_we = 1'b1; alu_flags = 3'b111;
        #1;
        check("rst_en",    {7'd0, flags_en}, 8'd0);
        check("rst_depth", {5'd0, depth},    8'd0);
        check("rst_busy",  {7'd0, busy},     8'd0);
        check("rst_err",   {6'd0, ovf_err, unf_err}, 8'd0);
        clear_in();
        step();
        rst_n = 1'b1;
        #1;

        // ALU path: same-cycle enable, visible in take next cycle.
        alu_we = 1'b1; alu_flags = 3'b101;
        #1;
        check("alu_en", {7'd0, flags_en}, 8'd1);
        check("alu_d",  {5'd0, flags_d},  8'h05);
        step();
        clear_in();
        cond = 3'b001;
        #1;
        check("alu_take_z", {7'd0, take}, 8'd1);

        // Push 010, overwrite with 000, then restore.
        alu_we = 1'b1; alu_flags = 3'b010;
        step();
        clear_in();
        int_save = 1'b1;
        step();
        int_save = 1'b0;
        check("push_depth", {5'd0, depth}, 8'd1);
        alu_we = 1'b1; alu_flags = 3'b000;
        step();
        clear_in();
        rti = 1'b1;
        #1;
        check("rti_cyc_en", {7'd0, flags_en}, 8'd0);
        step();
        rti = 1'b0;
        check("pop_busy",  {7'd0, busy},     8'd1);
        check("pop_en",    {7'd0, flags_en}, 8'd1);
        check("pop_d",     {5'd0, flags_d},  8'h02);
        check("pop_depth", {5'd0, depth},    8'd0);
        step();
        check("pop_busy_off", {7'd0, busy}, 8'd0);
        check("pop_flags_q",  {5'd0, freg}, 8'h02);

        // Push with a simultaneous ALU write saves the ALU value.
        alu_we = 1'b1; alu_flags = 3'b110; int_save = 1'b1;
        step();
        clear_in();
        check("pushalu_depth", {5'd0, depth}, 8'd1);
        alu_we = 1'b1; alu_flags = 3'b001;
        step();
        clear_in();
        rti = 1'b1;
        step();
        rti = 1'b0;
        step();
        check("pushalu_restore", {5'd0, freg}, 8'h06);

        // Overflow, LIFO order, underflow.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alu_we = 1'b1; alu_flags = vals[i]; int_save = 1'b1;
            step();
            clear_in();
            if (i == 3) check("full_no_ovf", {7'd0, ovf_err}, 8'd0);
        end
        check("ovf_depth", {5'd0, depth},   8'd4);
        check("ovf_err",   {7'd0, ovf_err}, 8'd1);
        for (int i = 3; i >= 0; i--) begin
            rti = 1'b1;
            step();
            rti = 1'b0;
            check("lifo_d", {5'd0, flags_d}, {5'd0, vals[i]});
            step();
            check("lifo_q", {5'd0, freg}, {5'd0, vals[i]});
        end
        check("lifo_depth", {5'd0, depth}, 8'd0);
        rti = 1'b1;
        #1;
        check("unf_no_en", {7'd0, flags_en}, 8'd0);
        step();
        rti = 1'b0;
        check("unf_err",   {7'd0, unf_err}, 8'd1);
        check("unf_busy",  {7'd0, busy},    8'd0);
        check("unf_flags", {5'd0, freg},    8'h01);

        // Tail-chain with two entries.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            int_save = 1'b1;
            step();
            clear_in();
        end
        int_save = 1'b1; rti = 1'b1;
        step();
        clear_in();
        check("tail_depth", {5'd0, depth}, 8'd2);
        check("tail_busy",  {7'd0, busy},  8'd0);
        check("tail_err",   {6'd0, ovf_err, unf_err}, 8'd0);

        // Reset mid-POP.
        rti = 1'b1;
        step();
        rti = 1'b0;
        check("midpop_busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("midpop_depth", {5'd0, depth},    8'd0);
        check("midpop_busy0", {7'd0, busy},     8'd0);
        check("midpop_en",    {7'd0, flags_en}, 8'd0);
        step();
        rst_n = 1'b1;
        #1;

        // Condition sweep and the IDLE write path, with flags_q overridden.
        use_ext = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                cond      = take_tab[c].cond;
                ext_flags = 3'(f);
                #1;
                check($sformatf("take_c%0d_f%0d", c, f), {7'd0, take}, {7'd0, take_tab[c].truth[f]});
            end
        end
        for (int i = 0; i < 5; i++) begin
            alu_we    = wr_tab[i].we;
            alu_flags = wr_tab[i].alu;
            ext_flags = wr_tab[i].cur;
            #1;
            check($sformatf("wr%0d_en", i), {7'd0, flags_en}, {7'd0, wr_tab[i].exp_en});
            check($sformatf("wr%0d_d", i),  {5'd0, flags_d},  {5'd0, wr_tab[i].exp_d});
        end
        clear_in();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/flags_ctrl.md
# flags_ctrl

Controller that owns the write port of the CPU's 3-bit condition-flags register (Z, V, N). It arbitrates flag updates from the ALU and the interrupt-return path, and keeps a LIFO shadow stack of flags across nested interrupts. It also evaluates branch conditions against the current flags. It sits between the execute stage, the interrupt controller and the flags register, and drives that register's `en` and `d` inputs.

## Interface
- `DEPTH`, default 4: shadow-stack entries (maximum interrupt nesting); power of two, ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_we`  in  1  ALU requests a flag update this cycle.
- `alu_flags`  in  3  new flags {Z, V, N}, bit 2 = Z, bit 1 = V, bit 0 = N.
- `int_save`  in  1  single-cycle pulse: interrupt accepted, push current flags.
- `rti`  in  1  single-cycle pulse: return from interrupt, pop flags.
- `flags_q`  in  3  current flags-register output.
- `cond`  in  3  branch condition code.
- `flags_en`  out  1  write enable to the flags register.
- `flags_d`  out  3  write data to the flags register.
- `busy`  out  1  restore in progress; the pipeline and interrupt controller stall.
- `take`  out  1  branch condition true (combinational from `cond`, `flags_q`).
- `depth`  out  clog2(DEPTH)+1  occupied stack entries.
- `ovf_err`  out  1  sticky: push attempted while full.
- `unf_err`  out  1  sticky: pop attempted while empty.

## Operation
- FSM states: IDLE, POP. Reset leads to IDLE.
- IDLE, `rti`=1, `int_save`=0, stack non-empty: latch the top entry into a restore register, decrement `depth`, go to POP.
- IDLE, `rti`=1, stack empty: set `unf_err`, no write, stay in IDLE.
- POP, always: `flags_en`=1, `flags_d`=restore register, `busy`=1, return to IDLE next cycle. In POP, `alu_we`, `int_save` and `rti` are ignored; the upstream blocks must not assert them while `busy` is high.
- IDLE, `alu_we`=1 (and no pop starting): `flags_en`=1, `flags_d`=`alu_flags`, combinational in the same cycle.
- IDLE, `int_save`=1, `rti`=0: push onto the stack. The pushed value is `alu_flags` if `alu_we`=1 in the same cycle (the interrupted instruction completes first), otherwise `flags_q`. Increment `depth`. If `depth`=DEPTH, set `ovf_err`, drop the push, and leave `depth` unchanged.
- IDLE, `int_save`=1 and `rti`=1 together: tail-chain. No stack change, no error, no POP. An `alu_we` in that cycle is still applied.
- `rti` together with `alu_we` in IDLE: the pop wins and `alu_we` is dropped.
- Otherwise `flags_en`=0 and `flags_d`=`flags_q`.
- `take` by `cond`:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 N^V
  - 100 !(N^V)
  - 101 !Z & !(N^V)
  - 110 Z | (N^V)
  - 111 V
- `ovf_err` and `unf_err` clear only on reset.

## Timing
- Reset (async assert, sync release): state IDLE, `depth`=0, `busy`=0, `ovf_err`=`unf_err`=0, stack contents 0. `flags_en`=0 during reset.
- ALU path, zero latency: `alu_we` at cycle T gives `flags_en`=1 at T, and `flags_q` is updated after edge T+1.
- Restore path, one-cycle stall: `rti` at T gives `busy`=1 and `flags_en`=1 at T+1, `flags_q` holds the restored value from T+2, and `busy`=0 at T+2.
- Push is visible in `depth` the cycle after `int_save`.
- Reset asserted during POP: the write is aborted and `depth` goes to 0.

## Test plan
- Reset, then `alu_we`=1 with `alu_flags`=3'b101 -> `flags_en`=1 and `flags_d`=101 the same cycle; `take` for `cond`=001 is 1 the next cycle.
- Flags 3'b010, `int_save` -> `depth`=1; then `alu_we` with 000; then `rti` -> `busy`=1 for one cycle and `flags_q`=010 two cycles after `rti`, `depth`=0.
- `int_save` and `alu_we`=3'b110 in the same cycle, then `rti` -> restored value 110.
- DEPTH=4: five `int_save` pulses -> `depth`=4 and `ovf_err`=1; four `rti` restore the values in LIFO order; a fifth `rti` -> `unf_err`=1 and no `flags_en`.
- `int_save` and `rti` in the same cycle with `depth`=2 -> `depth` stays 2, no errors, `busy`=0.
- Sweep `cond` 0–7 against all 8 flag values and check `take` against the condition table; pull `rst_n` low mid-POP -> `depth`=0 and `busy`=0 immediately.
